// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
// Removes a per-packet header of n bytes (0..DATA_BYTE_WD) from the front of
// an AXI-Stream packet. The stripped bytes are reported right-aligned on
// header_out/header_keep with a one-cycle header_valid pulse. The remaining
// payload is realigned so that it starts at byte 0 of the first output beat.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   valid_strip       strip command valid; byte_strip_cnt = header length n
//   ready_strip       command accepted while the block is idle
//   valid_in/ready_in input beat handshake; data_in, keep_in (MSB-aligned), last_in
//   valid_out/ready_out output beat handshake; data_out, keep_out, last_out
//   header_out        stripped header bytes, right-aligned, first byte most significant
//   header_keep       right-aligned byte enables for header_out
//   header_valid      one-cycle pulse when header_out/header_keep are updated
//
// Byte 0 of a beat sits in the most significant byte of data_in/data_out.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic [DATA_WD-1:0]       data_in,
   input  logic [DATA_BYTE_WD-1:0]  keep_in,
   input  logic                     last_in,
   output logic                     ready_in,
   output logic                     valid_out,
   output logic [DATA_WD-1:0]       data_out,
   output logic [DATA_BYTE_WD-1:0]  keep_out,
   output logic                     last_out,
   input  logic                     ready_out,
   input  logic                     valid_strip,
   input  logic [BYTE_CNT_WD:0]     byte_strip_cnt,
   output logic                     ready_strip,
   output logic [DATA_WD-1:0]       header_out,
   output logic [DATA_BYTE_WD-1:0]  header_keep,
   output logic                     header_valid
);

   localparam int CW = BYTE_CNT_WD + 1;   // holds 0..DATA_BYTE_WD
   localparam int TW = BYTE_CNT_WD + 2;   // holds 0..2*DATA_BYTE_WD

   typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

   state_t              state;
   logic [CW-1:0]       n_reg;      // header length of the current packet
   logic [CW-1:0]       r_reg;      // bytes carried in hold between beats
   logic [CW-1:0]       flush_cnt;  // bytes left in hold for the FLUSH beat
   logic [DATA_WD-1:0]  hold;       // carried bytes, left-aligned, zero below

   // MSB-aligned run of cnt ones
   function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [TW-1:0] cnt);
      logic [DATA_BYTE_WD-1:0] res;
      res = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         res[DATA_BYTE_WD-1-i] = (TW'(i) < cnt);
      end
      return res;
   endfunction

   // LSB-aligned run of cnt ones
   function automatic logic [DATA_BYTE_WD-1:0] keep_lsb(input logic [TW-1:0] cnt);
      logic [DATA_BYTE_WD-1:0] res;
      res = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         res[i] = (TW'(i) < cnt);
      end
      return res;
   endfunction

   function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         cnt = cnt + CW'(k[i]);
      end
      return cnt;
   endfunction

   // Zero the bytes that keep_in marks invalid so realigned beats never
   // carry stale bytes into positions with keep_out=0.
   logic [DATA_WD-1:0] data_masked;
   genvar gi;
   generate
      for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_mask
         assign data_masked[DATA_WD-1-8*gi -: 8] =
            keep_in[DATA_BYTE_WD-1-gi] ? data_in[DATA_WD-1-8*gi -: 8] : 8'h00;
      end
   endgenerate

   logic              out_free;
   logic              accept;
   logic [CW-1:0]     k_cnt;
   logic [CW-1:0]     n_clamp;
   logic [CW-1:0]     hdr_cnt;
   logic [CW-1:0]     hdr_shift;
   logic [CW-1:0]     rest_cnt;
   logic [DATA_WD-1:0] hdr_data;
   logic [DATA_WD-1:0] first_rest;
   logic [TW-1:0]     total;
   logic [2*DATA_WD-1:0] comb_data;

   assign out_free    = !valid_out || ready_out;
   assign ready_in    = ((state == FIRST) || (state == BODY)) && out_free;
   assign ready_strip = (state == IDLE);
   assign accept      = valid_in && ready_in;

   assign k_cnt     = popcount(keep_in);
   assign n_clamp   = (byte_strip_cnt > CW'(DATA_BYTE_WD)) ? CW'(DATA_BYTE_WD) : byte_strip_cnt;

   // First beat: header is the first min(n,k) bytes, shifted down to the LSBs.
   assign hdr_cnt    = (n_reg < k_cnt) ? n_reg : k_cnt;
   assign hdr_shift  = CW'(DATA_BYTE_WD) - hdr_cnt;
   assign hdr_data   = data_masked >> {hdr_shift, 3'b000};
   assign first_rest = data_masked << {n_reg, 3'b000};
   assign rest_cnt   = (k_cnt > n_reg) ? (k_cnt - n_reg) : '0;

   // Body beats: hold bytes followed by the new beat, as a double-width word.
   // The upper half is the next output beat, the lower half the new hold.
   assign comb_data = {hold, {DATA_WD{1'b0}}} | ({data_masked, {DATA_WD{1'b0}}} >> {r_reg, 3'b000});
   assign total     = TW'(r_reg) + TW'(k_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         n_reg        <= '0;
         r_reg        <= '0;
         flush_cnt    <= '0;
         hold         <= '0;
         valid_out    <= 1'b0;
         data_out     <= '0;
         keep_out     <= '0;
         last_out     <= 1'b0;
         header_out   <= '0;
         header_keep  <= '0;
         header_valid <= 1'b0;
      end else begin
         header_valid <= 1'b0;
         if (valid_out && ready_out) begin
            valid_out <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (valid_strip) begin
                  n_reg <= n_clamp;
                  r_reg <= CW'(DATA_BYTE_WD) - n_clamp;
                  state <= FIRST;
               end
            end

            FIRST: begin
               if (accept) begin
                  header_out   <= hdr_data;
                  header_keep  <= keep_lsb(TW'(hdr_cnt));
                  header_valid <= 1'b1;
                  if (last_in) begin
                     // Single-beat packet. With k<=n nothing is left and this
                     // becomes the zero-length marker (data 0, keep 0).
                     valid_out <= 1'b1;
                     data_out  <= first_rest;
                     keep_out  <= keep_msb(TW'(rest_cnt));
                     last_out  <= 1'b1;
                     hold      <= '0;
                     state     <= IDLE;
                  end else begin
                     hold  <= first_rest;
                     state <= BODY;
                  end
               end
            end

            BODY: begin
               if (accept) begin
                  valid_out <= 1'b1;
                  data_out  <= comb_data[2*DATA_WD-1:DATA_WD];
                  if (last_in && (total <= TW'(DATA_BYTE_WD))) begin
                     keep_out <= keep_msb(total);
                     last_out <= 1'b1;
                     hold     <= '0;
                     state    <= IDLE;
                  end else begin
                     keep_out <= '1;
                     last_out <= 1'b0;
                     hold     <= comb_data[DATA_WD-1:0];
                     if (last_in) begin
                        flush_cnt <= CW'(total - TW'(DATA_BYTE_WD));
                        state     <= FLUSH;
                     end
                  end
               end
            end

            FLUSH: begin
               if (out_free) begin
                  valid_out <= 1'b1;
                  data_out  <= hold;
                  keep_out  <= keep_msb(TW'(flush_cnt));
                  last_out  <= 1'b1;
                  hold      <= '0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 Parameter DATA_WD, default 32: stream data width in bits, a multiple of 8.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8: bytes per beat.
REQ-003 Parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD): byte-count width.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data; byte 0 (first on the wire) is in [DATA_WD-1:DATA_WD-8].
- keep_in  in  DATA_BYTE_WD  byte enables, MSB-aligned (1111, 1110, 1100, 1000); only the last beat may be partial.
- last_in  in  1  last beat of the packet.
- ready_in  out  1  input beat accepted when valid_in&ready_in.
- valid_out, data_out, keep_out, last_out  out  1/DATA_WD/DATA_BYTE_WD/1  realigned payload stream, same byte order.
- ready_out  in  1  downstream ready.
- valid_strip  in  1  strip command valid.
- byte_strip_cnt  in  BYTE_CNT_WD+1  header length n, 0..DATA_BYTE_WD.
- ready_strip  out  1  command accepted on valid_strip&ready_strip.
- header_out  out  DATA_WD  stripped header bytes, right-aligned.
- header_keep  out  DATA_BYTE_WD  right-aligned enables for header_out, e.g. 0011.
- header_valid  out  1  one-cycle pulse when header_out is updated.

Function
REQ-005 FSM states SHALL be IDLE, FIRST, BODY and FLUSH.
REQ-006 IDLE: ready_strip=1 and ready_in=0; an accepted command latches n and moves to FIRST.
REQ-007 FIRST/BODY: ready_in=(!valid_out|ready_out); ready_strip=0.
REQ-008 FIRST beat accept (k = number of ones in keep_in):
- the first min(n,k) bytes go to header_out, right-aligned, first byte most significant.
- header_keep gets min(n,k) LSB ones; header_valid pulses next cycle.
- bytes n..DATA_BYTE_WD-1 go to the hold register (residual r=DATA_BYTE_WD-n).
- no output beat, except as required by REQ-011; next state is BODY.
REQ-009 BODY beat accept: output beat = {hold r bytes, first n bytes of data_in}; keep_out=1111; the hold register takes the remaining bytes of data_in.
REQ-010 When last_in is accepted with k valid bytes, total remaining bytes t=r+k (r = current hold count):
- if t<=DATA_BYTE_WD, emit one beat with keep_out MSB-aligned t ones and last_out=1, then go to IDLE.
- otherwise emit a full beat, go to FLUSH, then emit a beat of t-DATA_BYTE_WD bytes with last_out=1 and go to IDLE.
- ready_in=0 while in FLUSH.
REQ-011 If the FIRST beat is also last and k<=n, the block SHALL emit exactly one beat with keep_out=0000, last_out=1 and data_out=0 (zero-length marker), then go to IDLE.
REQ-012 n=0 SHALL pass the payload through unchanged with header_keep=0; header_valid still pulses.
REQ-013 Output registers SHALL hold stable while valid_out&!ready_out; no beat is dropped or duplicated.
REQ-014 Latency: an output beat SHALL be valid the cycle after the input beat that completes it is accepted.
REQ-015 Full throughput (one beat per cycle) SHALL be sustained while ready_out=1, except the one FLUSH cycle.
REQ-016 Unused data_out bytes (keep_out=0) SHALL be driven 0.
REQ-017 valid_in during IDLE SHALL be ignored (not accepted); byte_strip_cnt>DATA_BYTE_WD is treated as DATA_BYTE_WD.

Reset
REQ-018 rst_n low SHALL immediately force state IDLE and clear the hold register.
REQ-019 rst_n low SHALL immediately force valid_out=0, last_out=0, data_out=0, keep_out=0, header_out=0, header_keep=0, header_valid=0.
REQ-020 Reset mid-packet SHALL abandon the packet; ready_strip=1 in the first cycle after release.

Verification
REQ-021 n=2, beats AABBCCDD/11223344(last, keep 1111):
- header_out=0000AABB, header_keep=0011.
- out beat CCDD1122 keep 1111, then 33440000 keep 1100, last.
REQ-022 n=3, beats 01020304/05060708(last, keep 1000):
- out 04050000 keep 1100 in a single last beat; no FLUSH.
REQ-023 n=1, beats A1A2A3A4/B1B2B3B4(last, keep 1111):
- out A2A3A4B1 then B2B3B400 keep 1110 last (FLUSH path).
REQ-024 n=4, single beat DEADBEEF last:
- header_out=DEADBEEF keep 1111; one out beat keep 0000 last=1.
REQ-025 Backpressure:
- random ready_out with n=0 and a 5-beat packet -> output identical to input, data stable while stalled.
REQ-026 rst_n pulsed low mid-BODY:
- outputs zero at once; the next packet strips correctly with n=2.
